// File: rtl/video_timing_counter.sv
// Pixel/line counter pair for video timing generation, with constant
// compare strobes decoded from the count registers, a wrap pulse and a sticky overflow flag.
module video_timing_counter #(
  parameter int PCNT_W = 8,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              pclr,
  input  logic              cclr,
  input  logic              pc,
  output logic [PCNT_W-1:0] pcnt,
  output logic [CNT_W-1:0]  cnt,
  output logic [4:0]        pcnt_hit,
  output logic [12:0]       cnt_hit,
  output logic              pwrap,
  output logic              ovf
);

  // Element 0 is the LSB strobe.
  localparam logic [4:0][31:0] PIX_CMP = {
    32'd241, 32'd27, 32'd17, 32'd12, 32'd6
  };
  localparam logic [12:0][31:0] LIN_CMP = {
    32'd591, 32'd567, 32'd511, 32'd509, 32'd284, 32'd283, 32'd272,
    32'd261, 32'd45,  32'd44,  32'd21,  32'd13,  32'd10
  };

  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pwrap_q, pwrap_d;
  logic              ovf_q, ovf_d;
  logic              pix_full, lin_full, advance, lin_wrap;

  assign pix_full = &pcnt_q;
  assign lin_full = &cnt_q;
  // pc alone advances the line; a same-edge pixel wrap adds nothing extra.
  assign advance  = en & (pc | (pix_full & ~pclr));
  assign lin_wrap = ~cclr & advance & lin_full;

  always_comb begin
    pcnt_d = pcnt_q;
    if (pclr)    pcnt_d = '0;
    else if (en) pcnt_d = pcnt_q + 1'b1;

    cnt_d = cnt_q;
    if (cclr)         cnt_d = '0;
    else if (advance) cnt_d = cnt_q + 1'b1;

    pwrap_d = ~pclr & en & pix_full;
    ovf_d   = cclr ? 1'b0 : (ovf_q | lin_wrap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q  <= '0;
      cnt_q   <= '0;
      pwrap_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      cnt_q   <= cnt_d;
      pwrap_q <= pwrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pcnt  = pcnt_q;
  assign cnt   = cnt_q;
  assign pwrap = pwrap_q;
  assign ovf   = ovf_q;

  // Compare values too wide for the counter tie their strobe low.
  for (genvar i = 0; i < 5; i++) begin : g_pix_hit
    if ((PIX_CMP[i] >> PCNT_W) == 32'd0) begin : g_on
      assign pcnt_hit[i] = (pcnt_q == PIX_CMP[i][PCNT_W-1:0]);
    end else begin : g_off
      assign pcnt_hit[i] = 1'b0;
    end
  end

  for (genvar i = 0; i < 13; i++) begin : g_lin_hit
    if ((LIN_CMP[i] >> CNT_W) == 32'd0) begin : g_on
      assign cnt_hit[i] = (cnt_q == LIN_CMP[i][CNT_W-1:0]);
    end else begin : g_off
      assign cnt_hit[i] = 1'b0;
    end
  end

endmodule
